// File: rtl/alu_multiciclo.sv
// Multi-cycle ALU stage between the register bank read ports and its write-back port.
// Logic/add/sub finish in one execute cycle; MUL runs a 32-step shift-add sequence.
module alu_multiciclo (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [4:0]  rd,
  output logic [31:0] result,
  output logic [4:0]  aw,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic        zero,
  output logic        ovf,
  output logic        err
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_SLT = 4'b0111;
  localparam logic [3:0] OP_NOR = 4'b1100;
  localparam logic [3:0] OP_MUL = 4'b1000;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_MUL,
    S_DONE
  } state_t;

  state_t      state_q;
  logic [31:0] a_q, b_q, acc_q, result_q;
  logic [3:0]  op_q;
  logic [4:0]  rd_q, aw_q;
  logic [5:0]  cnt_q;
  logic        we_q, busy_q, done_q, zero_q, ovf_q, err_q;

  logic [31:0] sum_d, diff_d, res_d, acc_d;
  logic        ovf_d, err_d;

  always_comb begin
    sum_d  = a_q + b_q;
    diff_d = a_q - b_q;
    res_d  = '0;
    ovf_d  = 1'b0;
    err_d  = 1'b0;
    case (op_q)
      OP_AND: res_d = a_q & b_q;
      OP_OR:  res_d = a_q | b_q;
      OP_NOR: res_d = ~(a_q | b_q);
      OP_ADD: begin
        res_d = sum_d;
        ovf_d = (a_q[31] == b_q[31]) && (sum_d[31] != a_q[31]);
      end
      OP_SUB: begin
        res_d = diff_d;
        ovf_d = (a_q[31] != b_q[31]) && (diff_d[31] != a_q[31]);
      end
      OP_SLT: res_d = {31'b0, ($signed(a_q) < $signed(b_q))};
      default: err_d = 1'b1;
    endcase
  end

  // During MUL, a_q is the shifting multiplicand and b_q the shifting multiplier.
  always_comb begin
    acc_d = acc_q + (b_q[0] ? a_q : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      aw_q     <= '0;
      we_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            rd_q    <= rd;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= (op == OP_MUL) ? S_MUL : S_EXEC;
          end
        end
        S_EXEC: begin
          result_q <= res_d;
          zero_q   <= (res_d == '0);
          ovf_q    <= ovf_d;
          err_q    <= err_d;
          aw_q     <= rd_q;
          we_q     <= ~err_d;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_MUL: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= cnt_q + 6'd1;
          if (cnt_q == 6'd31) begin
            result_q <= acc_d;
            zero_q   <= (acc_d == '0);
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            aw_q     <= rd_q;
            we_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            state_q  <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          we_q    <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign result = result_q;
  assign aw     = aw_q;
  assign we     = we_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign zero   = zero_q;
  assign ovf    = ovf_q;
  assign err    = err_q;

endmodule

// File: tb/tb_alu_multiciclo.sv
// Bench for alu_multiciclo: directed cases plus random ops checked against an arithmetic model.
module tb_alu_multiciclo;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [4:0]  rd;
  logic [31:0] result;
  logic [4:0]  aw;
  logic        we, busy, done, zero, ovf, err;

  int checks = 0;
  int errors = 0;

  logic [31:0] e_res;
  logic [4:0]  e_aw;
  logic        e_zero, e_ovf, e_err;

  alu_multiciclo dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .op     (op),
    .a      (a),
    .b      (b),
    .rd     (rd),
    .result (result),
    .aw     (aw),
    .we     (we),
    .busy   (busy),
    .done   (done),
    .zero   (zero),
    .ovf    (ovf),
    .err    (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                output logic [31:0] r, output logic v, output logic e);
    longint      s;
    logic [63:0] p;
    r = '0; v = 1'b0; e = 1'b0;
    case (o)
      4'b0000: r = x & y;
      4'b0001: r = x | y;
      4'b1100: r = ~(x | y);
      4'b0010: begin
        s = longint'($signed(x)) + longint'($signed(y));
        r = x + y;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0110: begin
        s = longint'($signed(x)) - longint'($signed(y));
        r = x - y;
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      end
      4'b0111: r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      4'b1000: begin
        p = {32'b0, x} * {32'b0, y};
        r = p[31:0];
      end
      default: e = 1'b1;
    endcase
  endfunction

  // Issue one request at a negedge and follow it through DONE and one idle cycle.
  task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [4:0] r, input bit inject);
    logic [31:0] x_res;
    logic        x_ovf, x_err;
    int          lat, exp_lat;
    model(o, x, y, x_res, x_ovf, x_err);
    exp_lat = (o == 4'b1000) ? 33 : 2;
    start = 1'b1; op = o; a = x; b = y; rd = r;
    @(negedge clk);
    start = 1'b0; op = 4'($urandom); a = $urandom; b = $urandom; rd = 5'($urandom);
    lat = 1;
    chk("busy_after_start", busy, 1);
    while (!done && lat < 100) begin
      chk("busy_while_running", busy, 1);
      chk("no_we_before_done", we, 0);
      chk("result_holds", result, e_res);
      start = (inject && lat == 5);
      op    = 4'b0010;
      @(negedge clk);
      lat++;
      a = $urandom; b = $urandom;
    end
    start = 1'b0;
    chk("latency", 32'(lat), 32'(exp_lat));
    chk("done_seen", done, 1);
    chk("result", result, x_res);
    chk("aw", aw, r);
    chk("zero", zero, (x_res == 0));
    chk("ovf", ovf, x_ovf);
    chk("err", err, x_err);
    chk("we_at_done", we, !x_err);
    chk("busy_at_done", busy, 0);
    e_res = x_res; e_aw = r; e_zero = (x_res == 0); e_ovf = x_ovf; e_err = x_err;
    start = 1'b1; op = 4'b0000;
    @(negedge clk);
    start = 1'b0;
    chk("done_one_cycle", done, 0);
    chk("we_one_cycle", we, 0);
    chk("start_in_done_ignored", busy, 0);
    chk("result_hold_after", result, e_res);
    chk("aw_hold_after", aw, e_aw);
    @(negedge clk);
    chk("no_second_done", {done, we, busy}, 0);
    chk("flags_hold", {zero, ovf, err}, {e_zero, e_ovf, e_err});
  endtask

  logic [3:0]  op_tab [8];
  logic [31:0] edge_tab [4];

  initial begin
    logic [31:0] ra, rb;
    op_tab   = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100, 4'b1000, 4'b1011};
    edge_tab = '{32'h0, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF};
    e_res = '0; e_aw = '0; e_zero = 1'b0; e_ovf = 1'b0; e_err = 1'b0;

    rst_n = 1'b0; start = 1'b1; op = 4'b0010; a = 32'h5; b = 32'h7; rd = 5'd3;
    repeat (4) begin
      @(negedge clk);
      chk("reset_outputs", {result, aw, we, busy, done, zero, ovf, err}, '0);
    end
    start = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    chk("idle_after_reset", {busy, done, we}, 0);

    run_op(4'b0010, 32'h7FFFFFFF, 32'h1, 5'd5, 1'b0);
    run_op(4'b0110, 32'h1234, 32'h1234, 5'd6, 1'b0);
    run_op(4'b0111, 32'hFFFFFFFF, 32'h1, 5'd7, 1'b0);
    run_op(4'b1000, 32'h00010003, 32'h00020005, 5'd8, 1'b1);
    run_op(4'b1111, 32'h12345678, 32'h9ABCDEF0, 5'd9, 1'b0);

    start = 1'b1; op = 4'b1000; a = 32'hDEADBEEF; b = 32'h13579BDF; rd = 5'd10;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_clears", {result, aw, we, busy, done, zero, ovf, err}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    e_res = '0; e_aw = '0; e_zero = 1'b0; e_ovf = 1'b0; e_err = 1'b0;
    repeat (40) begin
      @(negedge clk);
      chk("no_done_after_abort", {done, we, busy}, 0);
    end
    run_op(4'b0000, 32'hF0F0F0F0, 32'hFF00FF00, 5'd11, 1'b0);

    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 3)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? edge_tab[$urandom_range(0, 3)] : $urandom;
      if (i % 7 == 3) rb = ra;
      run_op(op_tab[$urandom_range(0, 7)], ra, rb, 5'($urandom), (i % 5 == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
